// File: rtl/step_timer.sv
// step_timer: turns prescaler tick pulses into snake move steps.
// Counts ticks up to a programmable period, then raises move_req and holds it
// until the game FSM acknowledges. speed_up shortens the period down to a floor.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   en         in   run enable; low = idle, counters cleared
//   tick       in   one-clk time unit pulse from prescaler
//   speed_up   in   one-clk pulse, shortens the period
//   move_ack   in   game FSM accepts the pending step
//   move_req   out  step pending (registered)
//   overrun    out  sticky: a period completed while a step was pending
//   period_dbg out  current period in ticks
//   cnt_dbg    out  current tick count within the period
module step_timer #(
  parameter logic [15:0] INIT_TICKS = 16'd50,
  parameter logic [15:0] MIN_TICKS  = 16'd10,
  parameter logic [15:0] STEP_TICKS = 16'd5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        tick,
  input  logic        speed_up,
  input  logic        move_ack,
  output logic        move_req,
  output logic        overrun,
  output logic [15:0] period_dbg,
  output logic [15:0] cnt_dbg
);

  localparam int unsigned CW = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_REQ   = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] period_q, period_d;
  logic          move_req_q, move_req_d;
  logic          overrun_q, overrun_d;

  logic          complete_c;
  logic [CW:0]   floor_c;
  logic [CW-1:0] period_dec_c;

  // Completion uses cnt+1 >= period in 17 bits (equivalent to cnt >= period-1
  // without underflow); always against the pre-speed_up period.
  assign complete_c   = tick && ((17'({1'b0, cnt_q}) + 17'd1) >= 17'({1'b0, period_q}));

  // Saturating decrement, compared in 17 bits so MIN+STEP cannot wrap.
  assign floor_c      = 17'({1'b0, MIN_TICKS}) + 17'({1'b0, STEP_TICKS});
  assign period_dec_c = (17'({1'b0, period_q}) >= floor_c) ? (period_q - STEP_TICKS)
                                                           : MIN_TICKS;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      period_q   <= INIT_TICKS;
      move_req_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      period_q   <= period_d;
      move_req_q <= move_req_d;
      overrun_q  <= overrun_d;
    end
  end

  // Next-state and datapath logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    period_d   = speed_up ? period_dec_c : period_q;
    move_req_d = move_req_q;
    overrun_d  = overrun_q;

    case (state_q)
      S_IDLE: begin
        cnt_d      = '0;
        move_req_d = 1'b0;
        if (en) begin
          state_d   = S_COUNT;
          // Fresh run: initial period overrides a coincident speed_up.
          period_d  = INIT_TICKS;
          overrun_d = 1'b0;
        end
      end

      S_COUNT: begin
        if (!en) begin
          state_d    = S_IDLE;
          cnt_d      = '0;
          move_req_d = 1'b0;
        end else if (tick) begin
          if (complete_c) begin
            cnt_d      = '0;
            move_req_d = 1'b1;
            state_d    = S_REQ;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end

      S_REQ: begin
        if (!en) begin
          state_d    = S_IDLE;
          cnt_d      = '0;
          move_req_d = 1'b0;
        end else begin
          if (tick) begin
            cnt_d = complete_c ? '0 : (cnt_q + 16'd1);
          end
          // Ack together with a completion keeps the new step pending.
          if (complete_c && !move_ack) begin
            overrun_d = 1'b1;
          end else if (!complete_c && move_ack) begin
            move_req_d = 1'b0;
            state_d    = S_COUNT;
          end
        end
      end

      default: begin
        state_d    = S_IDLE;
        cnt_d      = '0;
        move_req_d = 1'b0;
      end
    endcase
  end

  assign move_req   = move_req_q;
  assign overrun    = overrun_q;
  assign period_dbg = period_q;
  assign cnt_dbg    = cnt_q;

endmodule
